vec_execute_unit: RTL and testbench
===================================

VEC_EXECUTE_UNIT -- requirements
Module: vec_execute_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: pipeline clock; all state updates on the falling edge, matching the pipeline registers.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_opcode, input, 5 bits: operation from the execute pipeline register.
REQ-004 SHALL have ports in_reg1_data and in_reg2_data, input, 32 bits each: scalar operands.
REQ-005 SHALL have port in_immediate, input, 8 bits: immediate operand.
REQ-006 SHALL have ports in_vec1_data and in_vec2_data, input, 64 bits each: eight 8-bit lanes, lane i = bits [8i+7:8i].
REQ-007 SHALL have port in_wb_register, input, 3 bits: destination register index.
REQ-008 SHALL have port stall, output, 1 bit: high while a multi-cycle op is in progress; drives the enable of the upstream register low.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid, one-cycle pulse.
REQ-010 SHALL have port out_is_vec, output, 1 bit: result targets the vector register file.
REQ-011 SHALL have port out_wb_register, output, 3 bits: destination index, registered with the result.
REQ-012 SHALL have ports out_scalar, output, 32 bits, and out_vec, output, 64 bits: results.
REQ-013 SHALL have port illegal, output, 1 bit: one-cycle pulse on an unknown opcode.

Function
REQ-014 Opcodes SHALL be: 00000 ADD (reg1+reg2), 00001 SUB (reg1-reg2), 00010 AND, 00011 ADDI (reg1+zero-extended imm), 01000 VADD, 01001 VSUB, 01010 VMUL, 01011 VSHL (each lane << imm[2:0]), 11110 NOP.
REQ-015 Scalar arithmetic SHALL wrap modulo 2^32; lane arithmetic SHALL wrap modulo 2^8 per lane, with no carry between lanes.
REQ-016 FSM states SHALL be IDLE and BUSY; inputs are sampled only in IDLE.
REQ-017 In IDLE, a sampled single-cycle op SHALL set the outputs on that same edge: out_valid=1, result, out_wb_register, out_is_vec (1 for V* ops).
REQ-018 A sampled NOP SHALL give out_valid=0, and the result outputs SHALL hold their previous values.
REQ-019 A sampled unknown opcode SHALL give illegal=1 and out_valid=0, with no other effect.
REQ-020 A sampled VMUL SHALL latch its operands and wb index, set lane counter=0, enter BUSY, and assert stall.
REQ-021 In BUSY, each edge SHALL compute the low 8 bits of lane[cnt] product, then increment cnt.
REQ-022 On the edge with cnt=7, the block SHALL write out_vec, set out_valid=1 and out_is_vec=1, and return to IDLE with stall=0.
REQ-023 VMUL latency SHALL be 8 edges after the capture edge; stall SHALL be high for exactly those 8 cycles.
REQ-024 In BUSY, inputs SHALL be ignored; the upstream stage holds them.
REQ-025 out_valid and illegal SHALL each be high for exactly one cycle per event.

Reset
REQ-026 When reset is high on an edge, the block SHALL go to IDLE with cnt=0, stall=0, out_valid=0, illegal=0, out_is_vec=0, out_wb_register=0, out_scalar=0, out_vec=0.
REQ-027 Reset during BUSY SHALL abort the VMUL without producing a result; reset overrides all other events.

Configuration
REQ-028 With macro VEC_SATURATE_EN defined, VADD and VSUB SHALL saturate each lane unsigned, clamping to 0..255.
REQ-029 Without VEC_SATURATE_EN, VADD and VSUB SHALL wrap per REQ-015.
REQ-030 The macro SHALL NOT affect any other opcode.

Structure
REQ-031 The opcode enum, NOP encoding 5'b11110, LANES=8 and LANE_W=8 SHALL reside in shared package vec_cpu_pkg.
REQ-032 Per-lane add, sub, shift and saturation SHALL be one sub-module, vec_lane_alu, instantiated 8 times.

Verification
REQ-033 ADD with reg1=0xFFFFFFFF, reg2=1, wb=3 SHALL give out_scalar=0, out_valid=1 and out_wb_register=3 on the same edge.
REQ-034 VADD with lane0 0xF0+0x20 SHALL give 0x10 without VEC_SATURATE_EN and 0xFF with it; the other lanes SHALL be independent.
REQ-035 VMUL with vec1=0x0807060504030201 and vec2=0x0202020202020202 SHALL give stall high for 8 cycles, then out_vec=0x100E0C0A08060402 with one out_valid pulse.
REQ-036 VMUL followed by reset asserted at BUSY cnt=4 SHALL give stall=0 and all outputs zero on that edge, with no out_valid.
REQ-037 Opcode 11111 SHALL give illegal=1 for one cycle, out_valid=0 and outputs unchanged.
REQ-038 VSHL with imm=0x0B and vec1 lanes=0x81 SHALL give every lane 0x08.

Source files
------------

// File: rtl/vec_cpu_pkg.sv
// rtl/vec_cpu_pkg.sv - shared opcodes, lane geometry and FSM states for the vector execute unit
package vec_cpu_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 8;
  localparam int VEC_W  = LANES * LANE_W;

  localparam logic [4:0] NOP_ENC = 5'b11110;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_ADDI = 5'b00011,
    OP_VADD = 5'b01000,
    OP_VSUB = 5'b01001,
    OP_VMUL = 5'b01010,
    OP_VSHL = 5'b01011,
    OP_NOP  = NOP_ENC
  } opcode_e;

  typedef enum logic [1:0] {
    LANE_ADD = 2'd0,
    LANE_SUB = 2'd1,
    LANE_SHL = 2'd2
  } lane_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// rtl/vec_lane_alu.sv - one 8-bit lane of add/sub/shift; VEC_SATURATE_EN clamps add/sub to 0..255
module vec_lane_alu
  import vec_cpu_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [2:0]        shamt,
  input  lane_op_e          op,
  output logic [LANE_W-1:0] y
);

  logic [LANE_W-1:0] add_res;
  logic [LANE_W-1:0] sub_res;

`ifdef VEC_SATURATE_EN
  logic [LANE_W:0] sum;
  logic [LANE_W:0] diff;

  // The ninth bit is the carry out on add and the borrow on sub.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign add_res = sum[LANE_W]  ? '1 : sum[LANE_W-1:0];
  assign sub_res = diff[LANE_W] ? '0 : diff[LANE_W-1:0];
`else
  assign add_res = a + b;
  assign sub_res = a - b;
`endif

  always_comb begin
    y = add_res;
    case (op)
      LANE_ADD: y = add_res;
      LANE_SUB: y = sub_res;
      LANE_SHL: y = a << shamt;
      default:  y = add_res;
    endcase
  end

endmodule

// File: rtl/vec_execute_unit.sv
// rtl/vec_execute_unit.sv - falling-edge scalar/vector execute stage with multi-cycle VMUL; VEC_SATURATE_EN selects saturating VADD/VSUB
module vec_execute_unit
  import vec_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        in_opcode,
  input  logic [31:0]       in_reg1_data,
  input  logic [31:0]       in_reg2_data,
  input  logic [7:0]        in_immediate,
  input  logic [VEC_W-1:0]  in_vec1_data,
  input  logic [VEC_W-1:0]  in_vec2_data,
  input  logic [2:0]        in_wb_register,
  output logic              stall,
  output logic              out_valid,
  output logic              out_is_vec,
  output logic [2:0]        out_wb_register,
  output logic [31:0]       out_scalar,
  output logic [VEC_W-1:0]  out_vec,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [VEC_W-1:0]  op_a_q, op_a_d;
  logic [VEC_W-1:0]  op_b_q, op_b_d;
  logic [VEC_W-1:0]  acc_q, acc_d;
  logic [2:0]        mul_wb_q, mul_wb_d;
  logic              stall_q, stall_d;
  logic              out_valid_q, out_valid_d;
  logic              out_is_vec_q, out_is_vec_d;
  logic [2:0]        out_wb_q, out_wb_d;
  logic [31:0]       out_scalar_q, out_scalar_d;
  logic [VEC_W-1:0]  out_vec_q, out_vec_d;
  logic              illegal_q, illegal_d;

  lane_op_e          lane_op;
  logic [VEC_W-1:0]  lane_res;
  logic [31:0]       scalar_res;
  logic [LANE_W-1:0] mul_lane;

  always_comb begin
    lane_op = LANE_ADD;
    case (in_opcode)
      OP_VSUB: lane_op = LANE_SUB;
      OP_VSHL: lane_op = LANE_SHL;
      default: lane_op = LANE_ADD;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_lane_alu u_lane (
      .a     (in_vec1_data[g*LANE_W +: LANE_W]),
      .b     (in_vec2_data[g*LANE_W +: LANE_W]),
      .shamt (in_immediate[2:0]),
      .op    (lane_op),
      .y     (lane_res[g*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    scalar_res = in_reg1_data + in_reg2_data;
    case (in_opcode)
      OP_SUB:  scalar_res = in_reg1_data - in_reg2_data;
      OP_AND:  scalar_res = in_reg1_data & in_reg2_data;
      OP_ADDI: scalar_res = in_reg1_data + {24'd0, in_immediate};
      default: scalar_res = in_reg1_data + in_reg2_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    acc_d        = acc_q;
    mul_wb_d     = mul_wb_q;
    stall_d      = stall_q;
    out_valid_d  = 1'b0;
    illegal_d    = 1'b0;
    out_is_vec_d = out_is_vec_q;
    out_wb_d     = out_wb_q;
    out_scalar_d = out_scalar_q;
    out_vec_d    = out_vec_q;
    mul_lane     = '0;

    case (state_q)
      ST_IDLE: begin
        case (in_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_ADDI: begin
            out_valid_d  = 1'b1;
            out_is_vec_d = 1'b0;
            out_wb_d     = in_wb_register;
            out_scalar_d = scalar_res;
          end
          OP_VADD, OP_VSUB, OP_VSHL: begin
            out_valid_d  = 1'b1;
            out_is_vec_d = 1'b1;
            out_wb_d     = in_wb_register;
            out_vec_d    = lane_res;
          end
          OP_VMUL: begin
            state_d  = ST_BUSY;
            cnt_d    = 3'd0;
            op_a_d   = in_vec1_data;
            op_b_d   = in_vec2_data;
            mul_wb_d = in_wb_register;
            stall_d  = 1'b1;
          end
          OP_NOP: ;
          default: illegal_d = 1'b1;
        endcase
      end
      ST_BUSY: begin
        // One lane product per edge keeps a single 8x8 multiplier.
        mul_lane = op_a_q[{cnt_q, 3'b000} +: LANE_W] * op_b_q[{cnt_q, 3'b000} +: LANE_W];
        acc_d[{cnt_q, 3'b000} +: LANE_W] = mul_lane;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d      = ST_IDLE;
          cnt_d        = 3'd0;
          stall_d      = 1'b0;
          out_valid_d  = 1'b1;
          out_is_vec_d = 1'b1;
          out_wb_d     = mul_wb_q;
          out_vec_d    = acc_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      acc_q        <= '0;
      mul_wb_q     <= 3'd0;
      stall_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_is_vec_q <= 1'b0;
      out_wb_q     <= 3'd0;
      out_scalar_q <= 32'd0;
      out_vec_q    <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      acc_q        <= acc_d;
      mul_wb_q     <= mul_wb_d;
      stall_q      <= stall_d;
      out_valid_q  <= out_valid_d;
      out_is_vec_q <= out_is_vec_d;
      out_wb_q     <= out_wb_d;
      out_scalar_q <= out_scalar_d;
      out_vec_q    <= out_vec_d;
      illegal_q    <= illegal_d;
    end
  end

  assign stall           = stall_q;
  assign out_valid       = out_valid_q;
  assign out_is_vec      = out_is_vec_q;
  assign out_wb_register = out_wb_q;
  assign out_scalar      = out_scalar_q;
  assign out_vec         = out_vec_q;
  assign illegal         = illegal_q;

endmodule

// File: tb/tb_vec_execute_unit.sv
// tb/tb_vec_execute_unit.sv - directed self-checking bench for vec_execute_unit
module tb_vec_execute_unit;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SUB  = 5'b00001;
  localparam logic [4:0] AND_ = 5'b00010;
  localparam logic [4:0] ADDI = 5'b00011;
  localparam logic [4:0] VADD = 5'b01000;
  localparam logic [4:0] VSUB = 5'b01001;
  localparam logic [4:0] VMUL = 5'b01010;
  localparam logic [4:0] VSHL = 5'b01011;
  localparam logic [4:0] NOP  = 5'b11110;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_opcode;
  logic [31:0] in_reg1_data, in_reg2_data;
  logic [7:0]  in_immediate;
  logic [63:0] in_vec1_data, in_vec2_data;
  logic [2:0]  in_wb_register;
  logic        stall, out_valid, out_is_vec, illegal;
  logic [2:0]  out_wb_register;
  logic [31:0] out_scalar;
  logic [63:0] out_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vec_execute_unit dut (
    .clk             (clk),
    .reset           (reset),
    .in_opcode       (in_opcode),
    .in_reg1_data    (in_reg1_data),
    .in_reg2_data    (in_reg2_data),
    .in_immediate    (in_immediate),
    .in_vec1_data    (in_vec1_data),
    .in_vec2_data    (in_vec2_data),
    .in_wb_register  (in_wb_register),
    .stall           (stall),
    .out_valid       (out_valid),
    .out_is_vec      (out_is_vec),
    .out_wb_register (out_wb_register),
    .out_scalar      (out_scalar),
    .out_vec         (out_vec),
    .illegal         (illegal)
  );

  task automatic drive(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [7:0] imm, input logic [63:0] v1, input logic [63:0] v2,
                       input logic [2:0] wb);
    in_opcode = op; in_reg1_data = r1; in_reg2_data = r2; in_immediate = imm;
    in_vec1_data = v1; in_vec2_data = v2; in_wb_register = wb;
  endtask

  task automatic tick;
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(ADD, 32'h1234_5678, 32'h1, 8'hFF, 64'hFFFF, 64'h1, 3'd7);
    tick();
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if ({illegal, out_is_vec, out_wb_register} !== 5'd0) begin n_bad++; $display("FAIL reset_flags: got %b want 0", {illegal, out_is_vec, out_wb_register}); end
    n_cmp++; if ({out_scalar, out_vec} !== 96'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {out_scalar, out_vec}); end
    reset = 1'b0;
  endtask

  task automatic test_scalar;
    drive(ADD, 32'hFFFF_FFFF, 32'h1, 8'h00, 64'h0, 64'h0, 3'd3);
    tick();
    n_cmp++; if ({out_valid, out_is_vec, out_wb_register, out_scalar} !== {1'b1, 1'b0, 3'd3, 32'h0}) begin n_bad++; $display("FAIL add_wrap: got %h want %h", {out_valid, out_is_vec, out_wb_register, out_scalar}, {1'b1, 1'b0, 3'd3, 32'h0}); end
    drive(SUB, 32'd5, 32'd7, 8'h00, 64'h0, 64'h0, 3'd1);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_scalar} !== {1'b1, 3'd1, 32'hFFFF_FFFE}) begin n_bad++; $display("FAIL sub_wrap: got %h want %h", {out_valid, out_wb_register, out_scalar}, {1'b1, 3'd1, 32'hFFFF_FFFE}); end
    drive(AND_, 32'hF0F0_1234, 32'h0FF0_FF00, 8'h00, 64'h0, 64'h0, 3'd2);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_scalar} !== {1'b1, 3'd2, 32'h00F0_1200}) begin n_bad++; $display("FAIL and: got %h want %h", {out_valid, out_wb_register, out_scalar}, {1'b1, 3'd2, 32'h00F0_1200}); end
    drive(ADDI, 32'h10, 32'hDEAD, 8'hF0, 64'h0, 64'h0, 3'd4);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_scalar} !== {1'b1, 3'd4, 32'h100}) begin n_bad++; $display("FAIL addi: got %h want %h", {out_valid, out_wb_register, out_scalar}, {1'b1, 3'd4, 32'h100}); end
    drive(NOP, 32'h5, 32'h5, 8'h00, 64'hAB, 64'hCD, 3'd6);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_scalar, out_vec} !== {1'b0, 3'd4, 32'h100, 64'h0}) begin n_bad++; $display("FAIL nop_hold: got %h want %h", {out_valid, out_wb_register, out_scalar, out_vec}, {1'b0, 3'd4, 32'h100, 64'h0}); end
  endtask

  task automatic test_vector;
    logic [63:0] exp_add, exp_sub;
`ifdef VEC_SATURATE_EN
    exp_add = 64'h80FF_FF11_00FF_08FF;
    exp_sub = 64'h0001_0203_0002_0001;
`else
    exp_add = 64'h8000_0011_0000_0810;
    exp_sub = 64'h0001_0203_F002_FF01;
`endif
    drive(VADD, 32'h0, 32'h0, 8'h00, 64'h7F01_8010_00FF_05F0, 64'h01FF_8001_0001_0320, 3'd6);
    tick();
    n_cmp++; if ({out_valid, out_is_vec, out_wb_register} !== {1'b1, 1'b1, 3'd6}) begin n_bad++; $display("FAIL vadd_flags: got %b want %b", {out_valid, out_is_vec, out_wb_register}, {1'b1, 1'b1, 3'd6}); end
    n_cmp++; if (out_vec !== exp_add) begin n_bad++; $display("FAIL vadd_lanes: got %h want %h", out_vec, exp_add); end
    n_cmp++; if (out_scalar !== 32'h100) begin n_bad++; $display("FAIL vadd_scalar_hold: got %h want 100", out_scalar); end
    drive(VSUB, 32'h0, 32'h0, 8'h00, 64'h0102_0304_1005_0080, 64'h0101_0101_2003_017F, 3'd5);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_vec} !== {1'b1, 3'd5, exp_sub}) begin n_bad++; $display("FAIL vsub: got %h want %h", {out_valid, out_wb_register, out_vec}, {1'b1, 3'd5, exp_sub}); end
    drive(VSHL, 32'h0, 32'h0, 8'h0B, 64'h8181_8181_8181_8181, 64'hFFFF, 3'd1);
    tick();
    n_cmp++; if ({out_valid, out_vec} !== {1'b1, 64'h0808_0808_0808_0808}) begin n_bad++; $display("FAIL vshl_imm_b: got %h want %h", {out_valid, out_vec}, {1'b1, 64'h0808_0808_0808_0808}); end
    drive(VSHL, 32'h0, 32'h0, 8'h01, 64'h0102_0408_1020_4080, 64'h0, 3'd7);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_vec} !== {1'b1, 3'd7, 64'h0204_0810_2040_8000}) begin n_bad++; $display("FAIL vshl_one: got %h want %h", {out_valid, out_wb_register, out_vec}, {1'b1, 3'd7, 64'h0204_0810_2040_8000}); end
  endtask

  task automatic test_illegal;
    drive(5'b11111, 32'h1, 32'h1, 8'h01, 64'h1, 64'h1, 3'd2);
    tick();
    n_cmp++; if ({illegal, out_valid} !== 2'b10) begin n_bad++; $display("FAIL illegal_pulse: got %b want 10", {illegal, out_valid}); end
    n_cmp++; if ({out_is_vec, out_wb_register, out_scalar, out_vec} !== {1'b1, 3'd7, 32'h100, 64'h0204_0810_2040_8000}) begin n_bad++; $display("FAIL illegal_hold: got %h want %h", {out_is_vec, out_wb_register, out_scalar, out_vec}, {1'b1, 3'd7, 32'h100, 64'h0204_0810_2040_8000}); end
    drive(5'b00100, 32'h1, 32'h1, 8'h01, 64'h1, 64'h1, 3'd2);
    tick();
    n_cmp++; if ({illegal, out_valid, out_wb_register} !== {2'b10, 3'd7}) begin n_bad++; $display("FAIL illegal_gap_op: got %b want 10111", {illegal, out_valid, out_wb_register}); end
    drive(NOP, 32'h0, 32'h0, 8'h00, 64'h0, 64'h0, 3'd0);
    tick();
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_one_cycle: got %b want 0", illegal); end
  endtask

  task automatic test_vmul;
    int stall_cycles;
    int edges;
    bit done;
    drive(VMUL, 32'h0, 32'h0, 8'h00, 64'h0807_0605_0403_0201, 64'h0202_0202_0202_0202, 3'd5);
    tick();
    n_cmp++; if ({stall, out_valid} !== 2'b10) begin n_bad++; $display("FAIL vmul_capture: got %b want 10", {stall, out_valid}); end
    stall_cycles = stall ? 1 : 0;
    edges = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i < 7) drive(ADD, 32'h1111, 32'h2222, 8'h03, 64'hFFFF_FFFF, 64'h1, 3'd1);
      else       drive(NOP, 32'h0, 32'h0, 8'h00, 64'h0, 64'h0, 3'd0);
      tick();
      edges++;
      if (out_valid) done = 1'b1;
      else if (stall) stall_cycles++;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL vmul_timeout: got no result want result within 20 edges"); end
    n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL vmul_latency: got %0d want 8", edges); end
    n_cmp++; if (stall_cycles !== 8) begin n_bad++; $display("FAIL vmul_stall_cycles: got %0d want 8", stall_cycles); end
    n_cmp++; if ({stall, out_is_vec, out_wb_register} !== {1'b0, 1'b1, 3'd5}) begin n_bad++; $display("FAIL vmul_flags: got %b want 0_1_101", {stall, out_is_vec, out_wb_register}); end
    n_cmp++; if (out_vec !== 64'h100E_0C0A_0806_0402) begin n_bad++; $display("FAIL vmul_result: got %h want 100e0c0a08060402", out_vec); end
    n_cmp++; if (out_scalar !== 32'h100) begin n_bad++; $display("FAIL vmul_ignores_inputs: got %h want 100", out_scalar); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vmul_single_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_busy;
    int valids;
    drive(VMUL, 32'h0, 32'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0303_0303_0303_0303, 3'd3);
    tick();
    drive(ADD, 32'h1, 32'h1, 8'h00, 64'h0, 64'h0, 3'd2);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if ({stall, out_valid} !== 2'b10) begin n_bad++; $display("FAIL busy_cnt4: got %b want 10", {stall, out_valid}); end
    reset = 1'b1;
    tick();
    n_cmp++; if ({stall, out_valid, illegal, out_is_vec, out_wb_register} !== 7'd0) begin n_bad++; $display("FAIL abort_flags: got %b want 0", {stall, out_valid, illegal, out_is_vec, out_wb_register}); end
    n_cmp++; if ({out_scalar, out_vec} !== 96'd0) begin n_bad++; $display("FAIL abort_data: got %h want 0", {out_scalar, out_vec}); end
    reset = 1'b0;
    drive(NOP, 32'h0, 32'h0, 8'h00, 64'h0, 64'h0, 3'd0);
    valids = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || stall) valids++;
    end
    n_cmp++; if (valids !== 0) begin n_bad++; $display("FAIL abort_no_result: got %0d active cycles want 0", valids); end
  endtask

  task automatic test_back_to_back;
    drive(ADD, 32'd1, 32'd2, 8'h00, 64'h0, 64'h0, 3'd1);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_scalar} !== {1'b1, 3'd1, 32'd3}) begin n_bad++; $display("FAIL b2b_add: got %h want %h", {out_valid, out_wb_register, out_scalar}, {1'b1, 3'd1, 32'd3}); end
    drive(ADDI, 32'd3, 32'd0, 8'd5, 64'h0, 64'h0, 3'd2);
    tick();
    n_cmp++; if ({out_valid, out_wb_register, out_scalar} !== {1'b1, 3'd2, 32'd8}) begin n_bad++; $display("FAIL b2b_addi: got %h want %h", {out_valid, out_wb_register, out_scalar}, {1'b1, 3'd2, 32'd8}); end
    drive(VADD, 32'd0, 32'd0, 8'h00, 64'h0101_0101_0101_0101, 64'h0102_0304_0506_0708, 3'd4);
    tick();
    n_cmp++; if ({out_valid, out_is_vec, out_vec} !== {2'b11, 64'h0203_0405_0607_0809}) begin n_bad++; $display("FAIL b2b_vadd: got %h want %h", {out_valid, out_is_vec, out_vec}, {2'b11, 64'h0203_0405_0607_0809}); end
    drive(NOP, 32'h0, 32'h0, 8'h00, 64'h0, 64'h0, 3'd0);
    tick();
    n_cmp++; if ({out_valid, out_scalar} !== {1'b0, 32'd8}) begin n_bad++; $display("FAIL b2b_nop: got %h want %h", {out_valid, out_scalar}, {1'b0, 32'd8}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scalar();
    test_vector();
    test_illegal();
    test_vmul();
    test_reset_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
